uart_tx: RTL and testbench

- UART serial transmitter: takes one parallel byte per write strobe and serialises it on TxD.
- Frame is 11 bits: start, 8 data bits LSB first, even parity, stop.
- Baud rate is selected at run time from an 8-entry table.
- Sits between a host/register interface and the off-chip TX pin; pairs with a receiver that uses the same baud table.

---
 rtl/uart_pkg.sv | 49 ++++
 rtl/uart_tx_if.sv | 15 +
 rtl/baud_controller.sv | 39 +++
 rtl/uart_tx.sv | 101 ++++++++++
 tb/tb_uart_tx.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud codes, divisor table, oversampling factor and TX states.
// Imported by the transmitter and by the receiver that reuses the same baud table.
`timescale 1ns/1ps
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int          DIV_W      = 16;

    localparam logic [2:0] BAUD_300    = 3'b000;
    localparam logic [2:0] BAUD_1200   = 3'b001;
    localparam logic [2:0] BAUD_4800   = 3'b010;
    localparam logic [2:0] BAUD_9600   = 3'b011;
    localparam logic [2:0] BAUD_19200  = 3'b100;
    localparam logic [2:0] BAUD_38400  = 3'b101;
    localparam logic [2:0] BAUD_57600  = 3'b110;
    localparam logic [2:0] BAUD_115200 = 3'b111;

    typedef logic [DIV_W-1:0] baud_div_t;

    typedef logic [2:0] tx_state_t;
    localparam tx_state_t ST_IDLE   = 3'd0;
    localparam tx_state_t ST_START  = 3'd1;
    localparam tx_state_t ST_DATA   = 3'd2;
    localparam tx_state_t ST_PARITY = 3'd3;
    localparam tx_state_t ST_STOP   = 3'd4;

    function automatic int unsigned baud_rate(input logic [2:0] code);
        case (code)
            BAUD_300:    return 300;
            BAUD_1200:   return 1200;
            BAUD_4800:   return 4800;
            BAUD_9600:   return 9600;
            BAUD_19200:  return 19200;
            BAUD_38400:  return 38400;
            BAUD_57600:  return 57600;
            default:     return 115200;
        endcase
    endfunction

    // Rounded clk_hz / (os * baud); the half-denominator term gives round-to-nearest.
    function automatic baud_div_t baud_div(input logic [2:0] code,
                                           input int unsigned clk_hz,
                                           input int unsigned os);
        int unsigned den;
        den = os * baud_rate(code);
        return baud_div_t'((clk_hz + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side bus of the UART transmitter: write strobe, data, baud code, enable and status.
`timescale 1ns/1ps
interface uart_tx_if;
    logic [7:0] Tx_DATA;
    logic [2:0] baud_select;
    logic       Tx_WR;
    logic       Tx_EN;
    logic       TxD;
    logic       Tx_BUSY;

    modport master (output Tx_DATA, baud_select, Tx_WR, Tx_EN,
                    input  TxD, Tx_BUSY);
    modport slave  (input  Tx_DATA, baud_select, Tx_WR, Tx_EN,
                    output TxD, Tx_BUSY);
endinterface

// File: rtl/baud_controller.sv
// Free-running baud tick generator: one-clock sample_enable every DIV clocks.
// restart zeroes the count so a new frame starts on a full-length bit.
`timescale 1ns/1ps
module baud_controller #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned OVERSAMPLE  = uart_pkg::OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] baud_select,
    input  logic       restart,
    output logic       sample_enable
);
    import uart_pkg::*;

    localparam baud_div_t RESET_DIV = baud_div(BAUD_300, CLK_FREQ_HZ, OVERSAMPLE);

    baud_div_t cnt;
    baud_div_t div_q;
    logic      wrap;

    assign wrap          = (cnt == div_q - 1'b1);
    assign sample_enable = wrap;

    // The divisor is only reloaded at a wrap or restart, so a select change never truncates a tick.
    // NOTE: sequential state is updated with non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            div_q <= RESET_DIV;
        end else if (restart || wrap) begin
            cnt   <= '0;
            div_q <= baud_div(baud_select, CLK_FREQ_HZ, OVERSAMPLE);
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 11-bit frame (start, 8 data LSB first, even parity, stop) at a
// run-time selectable baud rate; TxD and Tx_BUSY come straight from flops.
`timescale 1ns/1ps
module uart_tx #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned OVERSAMPLE  = uart_pkg::OVERSAMPLE
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);
    import uart_pkg::*;

    localparam int                TICK_W    = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);

    tx_state_t         state;
    logic [7:0]        shift_q;
    logic              parity_q;
    logic [TICK_W-1:0] tick_cnt;
    logic [2:0]        bit_cnt;
    logic              txd_q;
    logic              busy_q;
    logic              accept;
    logic              sample_enable;
    logic              bit_done;

    assign accept   = bus.Tx_WR && bus.Tx_EN && (state == ST_IDLE);
    assign bit_done = sample_enable && (tick_cnt == LAST_TICK);

    baud_controller #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .OVERSAMPLE  (OVERSAMPLE)
    ) u_baud (
        .clk           (clk),
        .rst           (rst),
        .baud_select   (bus.baud_select),
        .restart       (accept),
        .sample_enable (sample_enable)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else if (state != ST_IDLE && !bus.Tx_EN) begin
            // Disabling mid-frame drops the frame and returns the line to idle.
            state  <= ST_IDLE;
            txd_q  <= 1'b1;
            busy_q <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (accept) begin
                shift_q  <= bus.Tx_DATA;
                parity_q <= ^bus.Tx_DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
                state    <= ST_START;
                txd_q    <= 1'b0;
                busy_q   <= 1'b1;
            end
        end else if (sample_enable) begin
            tick_cnt <= bit_done ? '0 : tick_cnt + 1'b1;
            if (bit_done) begin
                case (state)
                    ST_START: begin
                        state <= ST_DATA;
                        txd_q <= shift_q[0];
                    end
                    ST_DATA: begin
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                            txd_q <= parity_q;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            txd_q   <= shift_q[1];
                        end
                    end
                    ST_PARITY: begin
                        state <= ST_STOP;
                        txd_q <= 1'b1;
                    end
                    default: begin
                        state  <= ST_IDLE;
                        txd_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.TxD     = txd_q;
    assign bus.Tx_BUSY = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frames sampled mid-bit against a frame model built
// from the line format and a real-valued baud divisor.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int unsigned CLK_HZ = 50_000_000;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    uart_tx_if bus();

    uart_tx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .OVERSAMPLE  (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #10 clk = ~clk;

    int unsigned rates [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};

    // Clocks per bit: 16 ticks of round(f_clk / (16 * baud)).
    function automatic int bit_clocks(input logic [2:0] sel);
        real div;
        div = real'(CLK_HZ) / (16.0 * real'(rates[sel]));
        return 16 * $rtoi(div + 0.5);
    endfunction

    // Expected line level during bit slot idx of a frame carrying d.
    function automatic logic model_bit(input logic [7:0] d, input int idx);
        int ones;
        ones = 0;
        for (int j = 0; j < 8; j++) ones += d[j];
        if (idx == 0)  return 1'b0;
        if (idx <= 8)  return d[idx-1];
        if (idx == 9)  return logic'(ones % 2);
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic launch(input logic [7:0] d, input logic [2:0] sel);
        @(negedge clk);
        bus.Tx_DATA     = d;
        bus.baud_select = sel;
        bus.Tx_WR       = 1'b1;
        @(posedge clk);
    endtask

    // Follows a frame accepted on the preceding rising edge; k counts falling edges after it.
    task automatic follow(input logic [7:0] d, input int p, input int nbits,
                          input bit busy_wr, input bit chain, input logic [7:0] next_d);
        int last;
        last = (nbits == 11) ? 11 * p : nbits * p;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus.Tx_WR   = 1'b0;
                bus.Tx_DATA = ~d;
                check("start_txd", bus.TxD, 0);
                check("start_busy", bus.Tx_BUSY, 1);
            end
            if (k == p - 1) check("start_len", bus.TxD, 0);
            if (k == p)     check("bit0_edge", bus.TxD, model_bit(d, 1));
            for (int i = 0; i < nbits; i++) begin
                if (k == i * p + p / 2) begin
                    check($sformatf("bit%0d_d%02h", i, d), bus.TxD, model_bit(d, i));
                    check($sformatf("busy%0d", i), bus.Tx_BUSY, 1);
                end
            end
            if (busy_wr && k == 3 * p) begin
                bus.Tx_WR   = 1'b1;
                bus.Tx_DATA = 8'hFF;
            end
            if (busy_wr && k == 3 * p + 1) bus.Tx_WR = 1'b0;
            if (nbits == 11 && k == last - 1) begin
                check("stop_busy", bus.Tx_BUSY, 1);
                check("stop_txd", bus.TxD, 1);
            end
            if (nbits == 11 && k == last) begin
                check("end_busy", bus.Tx_BUSY, 0);
                check("end_txd", bus.TxD, 1);
                if (chain) begin
                    bus.Tx_WR   = 1'b1;
                    bus.Tx_DATA = next_d;
                end
            end
        end
        if (chain) @(posedge clk);
    endtask

    task automatic idle_gap(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k % 50 == 0) begin
                check("gap_txd", bus.TxD, 1);
                check("gap_busy", bus.Tx_BUSY, 0);
            end
        end
    endtask

    task automatic abort_check(input string tag);
        @(negedge clk);
        bus.Tx_EN = 1'b0;
        @(negedge clk);
        check({tag, "_txd"}, bus.TxD, 1);
        check({tag, "_busy"}, bus.Tx_BUSY, 0);
        bus.Tx_EN = 1'b1;
    endtask

    logic [7:0] seq [3] = '{8'h55, 8'hCC, 8'h89};

    initial begin
        int         p115;
        logic [7:0] d;
        logic [7:0] d2;

        bus.Tx_WR       = 1'b0;
        bus.Tx_EN       = 1'b0;
        bus.Tx_DATA     = 8'h00;
        bus.baud_select = 3'b111;
        rst             = 1'b1;
        #100;
        check("rst_txd", bus.TxD, 1);
        check("rst_busy", bus.Tx_BUSY, 0);
        @(negedge clk);
        rst = 1'b0;

        // Writes while disabled are ignored.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.Tx_WR   = 1'b1;
            bus.Tx_DATA = 8'($urandom);
            @(negedge clk);
            bus.Tx_WR = 1'b0;
            check("dis_txd", bus.TxD, 1);
            check("dis_busy", bus.Tx_BUSY, 0);
        end
        bus.Tx_EN = 1'b1;

        p115 = bit_clocks(3'b111);
        launch(8'hAA, 3'b111);
        follow(8'hAA, p115, 11, 1'b0, 1'b0, 8'h00);
        idle_gap(100);

        foreach (seq[i]) begin
            launch(seq[i], 3'b111);
            follow(seq[i], p115, 11, 1'b0, 1'b0, 8'h00);
            idle_gap(200);
        end

        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom);
            launch(d, 3'b111);
            follow(d, p115, 11, 1'b0, 1'b0, 8'h00);
            idle_gap(20);
        end

        // Write while busy is dropped, then a write on the first idle clock chains a frame.
        d  = 8'($urandom);
        d2 = 8'($urandom);
        launch(d, 3'b111);
        follow(d, p115, 11, 1'b1, 1'b1, d2);
        follow(d2, p115, 11, 1'b0, 1'b0, 8'h00);
        idle_gap(20);

        launch(8'h3C, 3'b011);
        follow(8'h3C, bit_clocks(3'b011), 2, 1'b0, 1'b0, 8'h00);
        abort_check("abort9600");

        d = 8'($urandom);
        launch(d, 3'b110);
        follow(d, bit_clocks(3'b110), 11, 1'b0, 1'b0, 8'h00);
        idle_gap(20);

        launch(8'hA5, 3'b000);
        repeat (8000) @(negedge clk);
        bus.Tx_WR = 1'b0;
        check("b300_start_txd", bus.TxD, 0);
        check("b300_start_busy", bus.Tx_BUSY, 1);
        abort_check("abort300");

        d = 8'($urandom);
        launch(d, 3'b111);
        follow(d, p115, 5, 1'b0, 1'b0, 8'h00);
        abort_check("abort_data");
        @(negedge clk);
        bus.Tx_EN = 1'b0;
        bus.Tx_WR = 1'b1;
        @(negedge clk);
        bus.Tx_WR = 1'b0;
        check("dis_wr_busy", bus.Tx_BUSY, 0);
        bus.Tx_EN = 1'b1;

        // Asynchronous reset mid-frame, then a clean frame.
        d = 8'($urandom);
        launch(d, 3'b111);
        @(negedge clk);
        bus.Tx_WR = 1'b0;
        repeat (4 * p115 + p115 / 3) @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid_txd", bus.TxD, 1);
        check("rst_mid_busy", bus.Tx_BUSY, 0);
        @(negedge clk);
        rst = 1'b0;
        idle_gap(10);
        d = 8'($urandom);
        launch(d, 3'b111);
        follow(d, p115, 11, 1'b0, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
